// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants and capture FSM encoding.
// Imported by the interface, the FIFO top and the bench.
package uart_rx_fifo_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and consumer-side signals of the UART RX FIFO.
// The master modport is the environment; slave is the FIFO block.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  import uart_rx_fifo_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_rdy;
  logic              rx_rdy_clr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              overrun_clr;

  modport master (
    output rx_data, rx_rdy, rd_en, overrun_clr,
    input  rx_rdy_clr, rd_data, rd_valid,
    input  empty, full, count, overrun
  );

  modport slave (
    input  rx_data, rx_rdy, rd_en, overrun_clr,
    output rx_rdy_clr, rd_data, rd_valid,
    output empty, full, count, overrun
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port.
// Flags come only from registers, so rd_en/wr_en never reach them.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [ADDR_W:0] count
);

  localparam logic [ADDR_W:0] ONE = 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [W-1:0]    rdat_q, rdat_d;
  logic            rv_q, rv_d;
  logic            wr_ok, rd_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                 (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  // Both gates use the pre-edge flags: a same-edge read never frees a slot.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    rdat_d = rdat_q;
    rv_d   = rd_ok;
    if (wr_ok) wptr_d = wptr_q + ONE;
    if (rd_ok) begin
      rptr_d = rptr_q + ONE;
      rdat_d = mem_q[rptr_q[ADDR_W-1:0]];
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rdat_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rdat_q <= rdat_d;
      rv_q   <= rv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data  = rdat_q;
  assign rd_valid = rv_q;
  assign count    = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each receiver byte once, acknowledges it,
// and queues it in a sync_fifo; dropped bytes raise a sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic clk,
  input logic rst,
  uart_rx_fifo_if.slave bus
);

  rx_state_e state_q, state_d;
  logic      ovr_q, ovr_d;
  logic      cap;
  logic      wr_en;
  logic      drop;

  // Capture only from IDLE, so a byte held across ACK is written once.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rx_rdy) begin
          cap     = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!bus.rx_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = cap & ~bus.full;
  assign drop  = cap & bus.full;

  always_comb begin
    ovr_d = ovr_q;
    if (drop)                 ovr_d = 1'b1;
    else if (bus.overrun_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_rdy_clr = (state_q == ACK);
  assign bus.overrun    = ovr_q;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (bus.rx_data),
    .rd_en    (bus.rd_en),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .empty    (bus.empty),
    .full     (bus.full),
    .count    (bus.count)
  );

endmodule
